// File: rtl/bs_isa_pkg.sv
// Shared ISA definitions for the bit-sliced PE dispatcher: opcodes, instruction fields,
// dispatcher state encoding and per-opcode execution budgets.
package bs_isa_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd1;
  localparam logic [OP_W-1:0] OP_MUL   = 6'd2;
  localparam logic [OP_W-1:0] OP_EAST  = 6'd5;
  localparam logic [OP_W-1:0] OP_SOUTH = 6'd7;
  localparam logic [OP_W-1:0] OP_NORTH = 6'd8;
  localparam logic [OP_W-1:0] OP_SHL   = 6'd9;
  localparam logic [OP_W-1:0] OP_SHR   = 6'd10;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS1_MSB = 20;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_MSB = 15;
  localparam int unsigned RS2_LSB = 11;

  typedef struct packed {
    logic [OPC_MSB-OPC_LSB:0] opcode;
    logic [RD_MSB-RD_LSB:0]   rd;
    logic [RS1_MSB-RS1_LSB:0] rs1;
    logic [RS2_MSB-RS2_LSB:0] rs2;
    logic [RS2_LSB-1:0]       rsvd;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } disp_state_t;

  // Cycles the controller needs for each opcode with N slices; 0 marks an unsupported opcode.
  function automatic int unsigned op_budget(input logic [OP_W-1:0] op, input int unsigned n);
    case (op)
      OP_ADD, OP_SUB: return 3 * n + 1;
      OP_MUL:         return 2 * n * n + n + 3;
      OP_EAST:        return n + 2;
      OP_SOUTH:       return n + 1;
      OP_NORTH:       return n + 2;
      OP_SHL, OP_SHR: return 2 * n + 1;
      default:        return 0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_EAST, OP_SOUTH, OP_NORTH, OP_SHL, OP_SHR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned budget_w(input int unsigned n);
    return $clog2(2 * n * n + n + 4);
  endfunction

endpackage

// File: rtl/bs_instr_fifo.sv
// Instruction buffer: DEPTH x WIDTH synchronous FIFO with wrap-bit pointers,
// allowing simultaneous push and pop at any occupancy including full.
module bs_instr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; empty/full come from the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bs_instr_dispatcher.sv
// Issue stage for the bit-sliced PE controller: buffers host instructions and issues each one
// for its fixed cycle budget. Define BS_DISPATCH_PERF_EN to add the stall_cycles counter.
module bs_instr_dispatcher
  import bs_isa_pkg::*;
#(
  parameter int unsigned LENGTH     = 32,
  parameter int unsigned SLICE_SIZE = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr_data,
  output logic                instr_ready,
  output logic                ctrl_start,
  output logic [INSTR_W-1:0]  ctrl_instruction,
  output logic                busy,
  output logic                illegal_err,
  output logic [15:0]         issued_count
`ifdef BS_DISPATCH_PERF_EN
  ,output logic [31:0]        stall_cycles
`endif
);

  localparam int unsigned N      = LENGTH / SLICE_SIZE;
  localparam int unsigned CNT_W  = budget_w(N);
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] B_ADD   = CNT_W'(op_budget(OP_ADD, N));
  localparam logic [CNT_W-1:0] B_MUL   = CNT_W'(op_budget(OP_MUL, N));
  localparam logic [CNT_W-1:0] B_EAST  = CNT_W'(op_budget(OP_EAST, N));
  localparam logic [CNT_W-1:0] B_SOUTH = CNT_W'(op_budget(OP_SOUTH, N));
  localparam logic [CNT_W-1:0] B_NORTH = CNT_W'(op_budget(OP_NORTH, N));
  localparam logic [CNT_W-1:0] B_SHIFT = CNT_W'(op_budget(OP_SHL, N));

  disp_state_t        state;
  disp_state_t        state_nxt;
  logic               push_acc;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [OCC_W-1:0]   fifo_count;
  logic [OCC_W-1:0]   occ_nxt;
  logic [INSTR_W-1:0] fifo_rdata;
  instr_t             head;
  logic               head_legal;
  logic [CNT_W-1:0]   head_budget;
  logic [CNT_W-1:0]   budget_cnt;
  logic               issue_load;
  logic               drop;

  assign push_acc = instr_valid && !fifo_full;
  assign head     = instr_t'(fifo_rdata);
  assign occ_nxt  = fifo_count + OCC_W'(push_acc) - OCC_W'(fifo_pop);

  bs_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_acc),
    .push_data (instr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head decode: legality and budget via constant table lookup.
  always_comb begin
    head_legal  = op_legal(head.opcode);
    head_budget = '0;
    case (head.opcode)
      OP_ADD, OP_SUB: head_budget = B_ADD;
      OP_MUL:         head_budget = B_MUL;
      OP_EAST:        head_budget = B_EAST;
      OP_SOUTH:       head_budget = B_SOUTH;
      OP_NORTH:       head_budget = B_NORTH;
      OP_SHL, OP_SHR: head_budget = B_SHIFT;
      default:        head_budget = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // GAP makes the same issue decision as IDLE so back-to-back starts are B+2 apart.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_GAP: state_nxt = (!fifo_empty && head_legal) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:        state_nxt = ST_RUN;
      ST_RUN:          if (budget_cnt == CNT_W'(1)) state_nxt = ST_GAP;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_load = 1'b0;
    drop       = 1'b0;
    if ((state == ST_IDLE) || (state == ST_GAP)) begin
      issue_load = !fifo_empty && head_legal;
      drop       = !fifo_empty && !head_legal;
    end
    fifo_pop = issue_load || drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_start       <= 1'b0;
      ctrl_instruction <= '0;
      busy             <= 1'b0;
      instr_ready      <= 1'b1;
      illegal_err      <= 1'b0;
      issued_count     <= '0;
      budget_cnt       <= '0;
    end else begin
      ctrl_start  <= issue_load;
      busy        <= (state_nxt != ST_IDLE) || (occ_nxt != '0);
      instr_ready <= (occ_nxt != OCC_W'(FIFO_DEPTH));
      if (drop) illegal_err <= 1'b1;
      if (issue_load) begin
        ctrl_instruction <= fifo_rdata;
        issued_count     <= issued_count + 16'd1;
        budget_cnt       <= head_budget;
      end else if (state == ST_RUN) begin
        budget_cnt <= budget_cnt - CNT_W'(1);
      end
    end
  end

`ifdef BS_DISPATCH_PERF_EN
  // Host back-pressure cycles, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (instr_valid && !instr_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bs_instr_dispatcher.sv
// Self-checking bench for bs_instr_dispatcher: directed scenarios plus random traffic checked
// against a queue-and-timeline reference model (LENGTH=32, SLICE_SIZE=4, FIFO_DEPTH=16).
module tb_bs_instr_dispatcher;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        instr_ready;
  logic        ctrl_start;
  logic [31:0] ctrl_instruction;
  logic        busy;
  logic        illegal_err;
  logic [15:0] issued_count;
`ifdef BS_DISPATCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  bs_instr_dispatcher #(
    .LENGTH     (32),
    .SLICE_SIZE (4),
    .FIFO_DEPTH (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instr_data       (instr_data),
    .instr_ready      (instr_ready),
    .ctrl_start       (ctrl_start),
    .ctrl_instruction (ctrl_instruction),
    .busy             (busy),
    .illegal_err      (illegal_err),
    .issued_count     (issued_count)
`ifdef BS_DISPATCH_PERF_EN
    ,.stall_cycles    (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending instructions plus a timeline of cycle indices.
  logic [31:0] q[$];
  int          cyc;
  int          free_at;
  int          issue_cyc;
  int          gap_cyc;
  logic        exp_start;
  logic [31:0] exp_instr;
  logic        exp_err;
  logic [15:0] exp_cnt;
  int          stall_exp;
  int          vectors;
  int          miscompares;

  localparam int NS = 8;

  function automatic int budget(input logic [5:0] op);
    case (op)
      6'd0, 6'd1:  return 3 * NS + 1;
      6'd2:        return 2 * NS * NS + NS + 3;
      6'd5:        return NS + 2;
      6'd7:        return NS + 1;
      6'd8:        return NS + 2;
      6'd9, 6'd10: return 2 * NS + 1;
      default:     return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_busy;
    exp_busy = ((cyc >= issue_cyc) && (cyc <= gap_cyc)) || (q.size() > 0);
    check("ctrl_start", 32'(ctrl_start), 32'(exp_start));
    check("ctrl_instruction", ctrl_instruction, exp_instr);
    check("busy", 32'(busy), 32'(exp_busy));
    check("instr_ready", 32'(instr_ready), 32'(q.size() < 16));
    check("illegal_err", 32'(illegal_err), 32'(exp_err));
    check("issued_count", 32'(issued_count), 32'(exp_cnt));
`ifdef BS_DISPATCH_PERF_EN
    check("stall_cycles", stall_cycles, 32'(stall_exp));
`endif
  endtask

  task automatic model_clear();
    q.delete();
    exp_start = 1'b0;
    exp_instr = '0;
    exp_err   = 1'b0;
    exp_cnt   = '0;
    stall_exp = 0;
    issue_cyc = -10;
    gap_cyc   = -10;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare on the falling edge.
  task automatic step(input logic v, input logic [31:0] d);
    logic        rdy;
    logic [31:0] h;
    int          b;
    instr_valid = v;
    instr_data  = d;
    @(posedge clk);
    rdy = (q.size() < 16);
    if (v && !rdy) stall_exp++;
    exp_start = 1'b0;
    if ((cyc >= free_at) && (q.size() > 0)) begin
      h = q.pop_front();
      b = budget(h[31:26]);
      if (b > 0) begin
        exp_start = 1'b1;
        exp_instr = h;
        exp_cnt   = exp_cnt + 16'd1;
        issue_cyc = cyc + 1;
        gap_cyc   = cyc + 1 + b + 1;
        free_at   = gap_cyc;
      end else begin
        exp_err = 1'b1;
        free_at = cyc + 1;
      end
    end
    if (v && rdy) q.push_back(d);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (((q.size() > 0) || (cyc <= gap_cyc)) && (guard < 4000)) begin
      step(1'b0, 32'h0);
      guard++;
    end
    check("drain_bound", 32'(guard < 4000), 32'd1);
    idle(2);
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc += 2;
    free_at = cyc;
    check_all();
  endtask

  initial begin
    logic [5:0] ops [12];
    logic [5:0] op;
    ops = '{6'd0, 6'd1, 6'd2, 6'd5, 6'd7, 6'd8, 6'd9, 6'd10, 6'd3, 6'd6, 6'd11, 6'd63};
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    free_at     = 0;
    model_clear();
    instr_valid = 1'b0;
    instr_data  = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // Single add into an idle block.
    step(1'b1, 32'h0000_0000);
    idle(30);

    // Mult then east back-to-back.
    step(1'b1, 32'h0800_0000);
    step(1'b1, 32'h1400_0000);
    idle(160);

    // Illegal opcode 6 dropped, south still issued.
    step(1'b1, 32'h1800_0000);
    step(1'b1, 32'h1C00_0000);
    idle(15);

    // Fill the buffer behind a mult, then keep pushing against back-pressure.
    step(1'b1, 32'h0800_0000);
    for (int i = 0; i < 30; i++) step(1'b1, 32'h2000_0000 | 32'(i));
    drain();

    // Reset in the middle of a shift.
    step(1'b1, 32'h2400_0000);
    idle(8);
    async_reset();
    idle(30);

    // Random mixed traffic including illegal opcodes.
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 11)];
      step(($urandom_range(0, 3) == 0), {op, 26'($urandom)});
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
